// File: rtl/boot_image_sender_if.sv
// Boot-image link bundle: start/length request, image read port and UART line status.
// master = the sender engine, slave = the image memory / host side that drives it.
interface boot_image_sender_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] last_adr;
    logic [7:0]        mem_data;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_adr;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        input  start, last_adr, mem_data,
        output mem_en, mem_adr, tx, busy, done
    );

    modport slave (
        output start, last_adr, mem_data,
        input  mem_en, mem_adr, tx, busy, done
    );
endinterface

// File: rtl/boot_image_sender.sv
// Streams image bytes 0..last_adr out of a read port as 8N1 UART frames on tx.
// One read per byte; frames are separated by two extra idle-high cycles (fetch + load).
module boot_image_sender #(
    parameter int CLK_DIV = 87,
    parameter int ADDR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    boot_image_sender_if.master  bus
);
    localparam int                BAUD_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [3:0]        STOP_BIT  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [ADDR_W-1:0] end_adr_q, end_adr_d;
    logic [9:0]        shift_q, shift_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state, counters and registered line outputs; ce low holds everything.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        end_adr_d = end_adr_q;
        shift_d   = shift_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (ce) begin
            case (state_q)
                IDLE: begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                    if (bus.start) begin
                        end_adr_d = bus.last_adr;
                        adr_d     = '0;
                        busy_d    = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FETCH: begin
                    state_d = LOAD;
                end
                LOAD: begin
                    // tx goes low together with the frame load so the start bit begins next cycle
                    shift_d = {1'b1, bus.mem_data, 1'b0};
                    baud_d  = '0;
                    bit_d   = 4'd0;
                    tx_d    = 1'b0;
                    state_d = SEND;
                end
                SEND: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_d = '0;
                        if (bit_q == STOP_BIT) begin
                            tx_d = 1'b1;
                            if (adr_q == end_adr_q) begin
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                state_d = IDLE;
                            end else begin
                                adr_d   = adr_q + ADDR_W'(1);
                                state_d = FETCH;
                            end
                        end else begin
                            shift_d = {1'b1, shift_q[9:1]};
                            bit_d   = bit_q + 4'd1;
                            tx_d    = shift_q[1];
                        end
                    end else begin
                        baud_d = baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            done_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset taking priority over ce.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            end_adr_q <= '0;
            shift_q   <= 10'h3FF;
            baud_q    <= '0;
            bit_q     <= 4'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            end_adr_q <= end_adr_d;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.mem_en  = (state_q == FETCH);
    assign bus.mem_adr = adr_q;
    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_boot_image_sender.sv
// Bench for boot_image_sender: table of transfers, random transfers with ce gaps and
// stray starts, a mid-frame reset and a 2-bit-address full-image run, all checked
// against an expected tx stream built from the frame rules.
module tb_boot_image_sender;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       start;
    logic       sel;
    logic [7:0] last_drv;

    logic [7:0] img_a [256];
    logic [7:0] img_b [4];

    int checks = 0;
    int errors = 0;

    boot_image_sender_if #(.ADDR_W(8)) ifa ();
    boot_image_sender_if #(.ADDR_W(2)) ifb ();

    assign ifa.start    = start & ~sel;
    assign ifa.last_adr = last_drv;
    assign ifb.start    = start & sel;
    assign ifb.last_adr = last_drv[1:0];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifa.mem_en) ifa.mem_data <= img_a[ifa.mem_adr];
        if (ifb.mem_en) ifb.mem_data <= img_b[ifb.mem_adr];
    end

    boot_image_sender #(.CLK_DIV(D), .ADDR_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (ifa.master)
    );

    boot_image_sender #(.CLK_DIV(D), .ADDR_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (ifb.master)
    );

    logic       tx_s, busy_s, done_s, mem_en_s;
    logic [7:0] mem_adr_s;
    assign tx_s      = sel ? ifb.tx     : ifa.tx;
    assign busy_s    = sel ? ifb.busy   : ifa.busy;
    assign done_s    = sel ? ifb.done   : ifa.done;
    assign mem_en_s  = sel ? ifb.mem_en : ifa.mem_en;
    assign mem_adr_s = sel ? {6'd0, ifb.mem_adr} : ifa.mem_adr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] img_at(input logic s, input int i);
        return s ? img_b[i & 3] : img_a[i & 255];
    endfunction

    // Called at a negedge; start is presented for the next edge (T0).
    task automatic run_xfer(input logic s, input int last, input int stray, input int gap_at,
                            input int new_last, input int exp_cycles);
        bit         obs[$];
        bit         ex[$];
        int         reads[$];
        int         n_bytes, idx, busy_lo, errs, base;
        bit         prev_tx, prev_ce, stable_ok, ce_v, timed_out;
        logic [9:0] frame;
        logic [7:0] got;
        n_bytes   = last + 1;
        stable_ok = 1'b1;
        busy_lo   = 0;
        prev_ce   = 1'b1;
        prev_tx   = 1'b1;
        timed_out = 1'b0;
        sel       = s;
        last_drv  = 8'(last);
        start     = 1'b1;
        ce        = 1'b1;
        @(posedge clk);
        idx = 0;
        forever begin
            @(negedge clk);
            if (done_s === 1'b1) break;
            if (idx >= 4000) begin
                timed_out = 1'b1;
                break;
            end
            ce_v  = !(gap_at >= 0 && idx >= gap_at && idx < gap_at + 7);
            ce    = ce_v;
            start = (idx == stray);
            if (idx == 1) last_drv = 8'(new_last);
            if (!prev_ce && tx_s !== prev_tx) stable_ok = 1'b0;
            if (ce_v) obs.push_back(tx_s);
            if (ce_v && mem_en_s === 1'b1) reads.push_back(int'(mem_adr_s));
            if (busy_s !== 1'b1) busy_lo++;
            prev_tx = tx_s;
            prev_ce = ce_v;
            idx++;
        end
        start = 1'b0;
        ce    = 1'b1;
        check("timeout", int'(timed_out), 0);
        check("done_latency", obs.size(), exp_cycles);
        check("busy_low_before_done", busy_lo, 0);
        check("busy_at_done", int'(busy_s), 0);
        check("tx_hold_while_ce_low", int'(stable_ok), 1);
        check("mem_read_count", reads.size(), n_bytes);
        for (int i = 0; i < reads.size() && i < n_bytes; i++) check("mem_adr_seq", reads[i], i);

        for (int n = 0; n < n_bytes; n++) begin
            frame = {1'b1, img_at(s, n), 1'b0};
            ex.push_back(1'b1);
            ex.push_back(1'b1);
            for (int k = 0; k < 10; k++)
                for (int c = 0; c < D; c++) ex.push_back(frame[k]);
        end
        if (obs.size() == ex.size()) begin
            for (int n = 0; n < n_bytes; n++) begin
                base = n * (10 * D + 2);
                errs = 0;
                for (int j = 0; j < 10 * D + 2; j++)
                    if (obs[base + j] != ex[base + j]) errs++;
                check("frame_bit_errors", errs, 0);
                for (int k = 0; k < 8; k++) got[k] = obs[base + 2 + (k + 1) * D + D / 2];
                check("uart_rx_byte", int'(got), int'(img_at(s, n)));
            end
        end
    endtask

    typedef struct {
        int         last;
        logic [7:0] b0, b1, b2;
        int         stray;
        int         new_last;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [3];
    int   n_r, g;

    initial begin
        vecs[0] = '{last: 0, b0: 8'hA5, b1: 8'h00, b2: 8'h00, stray: -1, new_last: 0,   exp_cycles: 42};
        vecs[1] = '{last: 2, b0: 8'h00, b1: 8'hFF, b2: 8'h3C, stray: 0,  new_last: 200, exp_cycles: 126};
        vecs[2] = '{last: 4, b0: 8'h5A, b1: 8'h81, b2: 8'h7E, stray: 60, new_last: 1,   exp_cycles: 210};
        for (int i = 0; i < 256; i++) img_a[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) img_b[i] = 8'($urandom);

        rst = 1'b1; ce = 1'b1; start = 1'b0; sel = 1'b0; last_drv = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", int'(ifa.tx), 1);
        check("reset_busy", int'(ifa.busy), 0);
        check("reset_done", int'(ifa.done), 0);
        check("reset_mem_en", int'(ifa.mem_en), 0);
        check("reset_mem_adr", int'(ifa.mem_adr), 0);
        check("reset_b_tx", int'(ifb.tx), 1);
        rst = 1'b0;
        @(negedge clk);

        // Table transfers, back to back: each start lands in the previous done cycle.
        for (int v = 0; v < 3; v++) begin
            img_a[0] = vecs[v].b0;
            img_a[1] = vecs[v].b1;
            img_a[2] = vecs[v].b2;
            run_xfer(1'b0, vecs[v].last, vecs[v].stray, -1, vecs[v].new_last, vecs[v].exp_cycles);
        end

        // ce low for 7 cycles inside data bit 0 of the first frame.
        run_xfer(1'b0, 1, -1, 7, 0, 2 * (10 * D + 2));

        // Random transfers with stray starts, a ce gap and a moving last_adr.
        for (int r = 0; r < 6; r++) begin
            n_r = $urandom_range(0, 4);
            for (int i = 0; i < 5; i++) img_a[i] = 8'($urandom);
            g = $urandom_range(3, (n_r + 1) * (10 * D + 2) - 10);
            run_xfer(1'b0, n_r, $urandom_range(0, (n_r + 1) * 42 - 1), g,
                     $urandom_range(0, 255), (n_r + 1) * (10 * D + 2));
        end

        // Reset in the middle of a data bit, then a clean transfer from address 0.
        img_a[0] = 8'h00;
        img_a[1] = 8'h96;
        sel = 1'b0; last_drv = 8'd1; start = 1'b1; ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_tx", int'(ifa.tx), 1);
        check("rst_mid_busy", int'(ifa.busy), 0);
        check("rst_mid_mem_en", int'(ifa.mem_en), 0);
        check("rst_mid_done", int'(ifa.done), 0);
        check("rst_mid_mem_adr", int'(ifa.mem_adr), 0);
        rst = 1'b0;
        run_xfer(1'b0, 1, -1, -1, 1, 2 * (10 * D + 2));

        // 2-bit address image, full size: four reads, no wrap, then done.
        @(negedge clk);
        run_xfer(1'b1, 3, 50, -1, 0, 4 * (10 * D + 2));
        repeat (3) @(negedge clk);
        check("b_idle_after_full", int'(ifb.busy), 0);
        check("b_no_fifth_read", int'(ifb.mem_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
